// File: rtl/ibex_pkg.sv
// Shared types and constants for the register-file writeback slice.
package ibex_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    // Architectural zero register; never written and never a hazard source.
    localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

    // One registered writeback beat headed for the register file write port.
    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } wb_slot_t;

endpackage

// File: rtl/ibex_rf_wb_ld_fifo.sv
// In-order FIFO of outstanding load destination registers.
// Exposes every entry so the stage can match hazards against all pending rds.
module ibex_rf_wb_ld_fifo #(
    parameter int unsigned Depth     = 2,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            push_i,
    input  logic                            pop_i,
    input  logic [AddrWidth-1:0]            push_rd_i,
    output logic [AddrWidth-1:0]            head_rd_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [Depth-1:0]                ent_valid_o,
    output logic [Depth-1:0][AddrWidth-1:0] ent_rd_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [Depth-1:0]               valid_q, valid_d;
    logic [Depth-1:0][AddrWidth-1:0] rd_q, rd_d;

    // Pointer increment wrapping modulo Depth (Depth need not be a power of two).
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    // Next-state: pop clears the head entry, push fills the tail entry.
    // Push is applied after pop so a full FIFO may push and pop together.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        rd_d     = rd_q;
        if (pop_i && valid_q[rd_ptr_q]) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        if (push_i) begin
            valid_d[wr_ptr_q] = 1'b1;
            rd_d[wr_ptr_q]    = push_rd_i;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            rd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            rd_q     <= rd_d;
        end
    end

    assign head_rd_o   = rd_q[rd_ptr_q];
    assign full_o      = &valid_q;
    assign empty_o     = ~|valid_q;
    assign ent_valid_o = valid_q;
    assign ent_rd_o    = rd_q;

endmodule

// File: rtl/ibex_rf_wb_stage.sv
// Writeback stage in front of the register file write port.
// Merges execute results and in-order load responses into one registered
// slot, tracks pending load destinations and raises decode hazard stalls.
// Optional macro IBEX_RF_WB_BYPASS_EN: forward the slot to decode operands
// instead of stalling on a slot-register match.
module ibex_rf_wb_stage import ibex_pkg::*; #(
    parameter bit              RV32E      = 1'b0,
    parameter int unsigned     DataWidth  = RF_DATA_W,
    parameter int unsigned     NumRegs    = 32,
    parameter int unsigned     MaxLoads   = 2,
    localparam int unsigned    ADDR_WIDTH = $clog2(NumRegs)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  ex_is_load_i,
    input  logic [ADDR_WIDTH-1:0] ex_rd_i,
    input  logic [DataWidth-1:0]  ex_wdata_i,
    input  logic                  lsu_resp_valid_i,
    input  logic [DataWidth-1:0]  lsu_rdata_i,
    input  logic                  lsu_err_i,
    input  logic [ADDR_WIDTH-1:0] rs_a_i,
    input  logic [ADDR_WIDTH-1:0] rs_b_i,
    output logic                  stall_o,
    output logic [DataWidth-1:0]  fwd_a_o,
    output logic [DataWidth-1:0]  fwd_b_o,
    input  logic [DataWidth-1:0]  rf_rdata_a_i,
    input  logic [DataWidth-1:0]  rf_rdata_b_i,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DataWidth-1:0]  rf_wdata_o,
    output logic                  rf_we_o,
    output logic                  err_o
);

    wb_slot_t slot_q, slot_d;
    logic     err_q, err_d;

    logic [ADDR_WIDTH-1:0]                 ex_rd;
    logic [ADDR_WIDTH-1:0]                 head_rd;
    logic                                  fifo_full, fifo_empty;
    logic [MaxLoads-1:0]                   ent_valid;
    logic [MaxLoads-1:0][ADDR_WIDTH-1:0]   ent_rd;

    logic ex_accept, push, pop, resp_ok;
    logic ex_rd_pend, rs_a_pend, rs_b_pend;
    logic wb_hit_a, wb_hit_b;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DataWidth-1:0]  wb_data;

    // The rd path is identical in both configurations; range checks belong to decode.
    if (RV32E) begin : g_rv32e
        assign ex_rd = ex_rd_i;
    end else begin : g_rv32i
        assign ex_rd = ex_rd_i;
    end

    ibex_rf_wb_ld_fifo #(
        .Depth     (MaxLoads),
        .AddrWidth (ADDR_WIDTH)
    ) u_ld_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .pop_i       (pop),
        .push_rd_i   (ex_rd),
        .head_rd_o   (head_rd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ent_valid_o (ent_valid),
        .ent_rd_o    (ent_rd)
    );

    // Match execute rd and decode sources against every pending load rd.
    always_comb begin
        ex_rd_pend = 1'b0;
        rs_a_pend  = 1'b0;
        rs_b_pend  = 1'b0;
        for (int unsigned i = 0; i < MaxLoads; i++) begin
            if (ent_valid[i]) begin
                if (ent_rd[i] == ex_rd)  ex_rd_pend = 1'b1;
                if (ent_rd[i] == rs_a_i) rs_a_pend  = 1'b1;
                if (ent_rd[i] == rs_b_i) rs_b_pend  = 1'b1;
            end
        end
        ex_rd_pend = ex_rd_pend && (ex_rd != '0);
        rs_a_pend  = rs_a_pend  && (rs_a_i != '0);
        rs_b_pend  = rs_b_pend  && (rs_b_i != '0);
    end

    // Handshake: response owns the slot, loads need FIFO room, no WAW past a load.
    assign ex_ready_o = rst_ni
                     && !(lsu_resp_valid_i && !ex_is_load_i)
                     && !(ex_is_load_i && fifo_full)
                     && !ex_rd_pend;
    assign ex_accept  = ex_valid_i && ex_ready_o;
    assign push       = ex_accept && ex_is_load_i;
    assign pop        = lsu_resp_valid_i && !fifo_empty;
    assign resp_ok    = pop && !lsu_err_i;

    // Slot next-state: good load response first, then a non-load execute beat.
    always_comb begin
        slot_d       = slot_q;
        slot_d.valid = 1'b0;
        err_d        = lsu_resp_valid_i && (lsu_err_i || fifo_empty);
        if (resp_ok) begin
            slot_d.valid = 1'b1;
            slot_d.rd    = RF_ADDR_W'(head_rd);
            slot_d.data  = RF_DATA_W'(lsu_rdata_i);
        end else if (ex_accept && !ex_is_load_i) begin
            slot_d.valid = 1'b1;
            slot_d.rd    = RF_ADDR_W'(ex_rd);
            slot_d.data  = RF_DATA_W'(ex_wdata_i);
        end
    end

    // Writeback slot and error pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
            err_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            err_q  <= err_d;
        end
    end

    assign wb_rd   = ADDR_WIDTH'(slot_q.rd);
    assign wb_data = DataWidth'(slot_q.data);

    assign rf_we_o    = slot_q.valid && (slot_q.rd != REG_ZERO);
    assign rf_waddr_o = wb_rd;
    assign rf_wdata_o = wb_data;
    assign err_o      = err_q;

    // Decode read of a register the slot is writing this cycle.
    assign wb_hit_a = rf_we_o && (rs_a_i == wb_rd);
    assign wb_hit_b = rf_we_o && (rs_b_i == wb_rd);

`ifdef IBEX_RF_WB_BYPASS_EN
    assign fwd_a_o = wb_hit_a ? wb_data : rf_rdata_a_i;
    assign fwd_b_o = wb_hit_b ? wb_data : rf_rdata_b_i;
    assign stall_o = rs_a_pend || rs_b_pend;
`else
    assign fwd_a_o = rf_rdata_a_i;
    assign fwd_b_o = rf_rdata_b_i;
    assign stall_o = rs_a_pend || rs_b_pend || wb_hit_a || wb_hit_b;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_stage.sv
// Directed vector bench for ibex_rf_wb_stage (default parameters).
module tb_ibex_rf_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i, ex_ready_o, ex_is_load_i;
    logic [4:0]  ex_rd_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_resp_valid_i, lsu_err_i;
    logic [31:0] lsu_rdata_i;
    logic [4:0]  rs_a_i, rs_b_i;
    logic        stall_o;
    logic [31:0] fwd_a_o, fwd_b_o, rf_rdata_a_i, rf_rdata_b_i;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_we_o, err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    ibex_rf_wb_stage dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ex_valid_i       (ex_valid_i),
        .ex_ready_o       (ex_ready_o),
        .ex_is_load_i     (ex_is_load_i),
        .ex_rd_i          (ex_rd_i),
        .ex_wdata_i       (ex_wdata_i),
        .lsu_resp_valid_i (lsu_resp_valid_i),
        .lsu_rdata_i      (lsu_rdata_i),
        .lsu_err_i        (lsu_err_i),
        .rs_a_i           (rs_a_i),
        .rs_b_i           (rs_b_i),
        .stall_o          (stall_o),
        .fwd_a_o          (fwd_a_o),
        .fwd_b_o          (fwd_b_o),
        .rf_rdata_a_i     (rf_rdata_a_i),
        .rf_rdata_b_i     (rf_rdata_b_i),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .rf_we_o          (rf_we_o),
        .err_o            (err_o)
    );

    // One cycle of stimulus plus what must be observed in that same cycle.
    typedef struct {
        logic        v, ld;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        rv;
        logic [31:0] rdt;
        logic        er;
        logic [4:0]  ra, rb;
        logic        ck_rdy, e_rdy, e_stall, e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_err;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    function automatic vec_t mk(input bit v, input bit ld, input int rd, input logic [31:0] wd,
                                input bit rv, input logic [31:0] rdt, input bit er,
                                input int ra, input int rb,
                                input bit ck, input bit rdy, input bit stl,
                                input bit we, input int wa, input logic [31:0] ewd, input bit eerr);
        vec_t t;
        t.v = v; t.ld = ld; t.rd = 5'(rd); t.wd = wd;
        t.rv = rv; t.rdt = rdt; t.er = er;
        t.ra = 5'(ra); t.rb = 5'(rb);
        t.ck_rdy = ck; t.e_rdy = rdy; t.e_stall = stl;
        t.e_we = we; t.e_wa = 5'(wa); t.e_wd = ewd; t.e_err = eerr;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic [4:0] rd, input logic [31:0] wd,
                         input logic rv, input logic [31:0] rdt, input logic er,
                         input logic [4:0] ra, input logic [4:0] rb);
        ex_valid_i = v; ex_is_load_i = ld; ex_rd_i = rd; ex_wdata_i = wd;
        lsu_resp_valid_i = rv; lsu_rdata_i = rdt; lsu_err_i = er;
        rs_a_i = ra; rs_b_i = rb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        //            v ld rd wdata         rv rdata         er ra rb  ck rdy stl we wa wdata        err
        tbl[0]  = mk(1, 0, 5, 32'h1234_5678, 0, 32'h0,        0, 0, 0,  1, 1, 0,  0, 0, 32'h0,        0);
        tbl[1]  = mk(1, 0, 0, 32'hFFFF_0000, 0, 32'h0,        0, 0, 0,  1, 1, 0,  1, 5, 32'h1234_5678, 0);
        tbl[2]  = mk(0, 0, 0, 32'h0,         0, 32'h0,        0, 0, 0,  1, 1, 0,  0, 0, 32'h0,        0);
        tbl[3]  = mk(1, 1, 7, 32'h0,         0, 32'h0,        0, 7, 0,  1, 1, 0,  0, 0, 32'h0,        0);
        tbl[4]  = mk(0, 0, 0, 32'h0,         0, 32'h0,        0, 7, 0,  1, 1, 1,  0, 0, 32'h0,        0);
        tbl[5]  = mk(1, 0, 3, 32'h0000_0333, 1, 32'hDEAD_BEEF, 0, 7, 0,  1, 0, 1,  0, 0, 32'h0,        0);
        tbl[6]  = mk(1, 0, 3, 32'h0000_0333, 0, 32'h0,        0, 0, 0,  1, 1, 0,  1, 7, 32'hDEAD_BEEF, 0);
        tbl[7]  = mk(0, 0, 0, 32'h0,         0, 32'h0,        0, 7, 0,  1, 1, 0,  1, 3, 32'h0000_0333, 0);
        tbl[8]  = mk(1, 1, 10, 32'h0,        0, 32'h0,        0, 0, 0,  1, 1, 0,  0, 0, 32'h0,        0);
        tbl[9]  = mk(1, 1, 11, 32'h0,        0, 32'h0,        0, 10, 0, 1, 1, 1,  0, 0, 32'h0,        0);
        tbl[10] = mk(1, 1, 12, 32'h0,        0, 32'h0,        0, 0, 11, 1, 0, 1,  0, 0, 32'h0,        0);
        tbl[11] = mk(1, 0, 10, 32'h0000_AAAA, 0, 32'h0,       0, 0, 0,  1, 0, 0,  0, 0, 32'h0,        0);
        tbl[12] = mk(1, 1, 12, 32'h0,        1, 32'h0000_1010, 0, 0, 0, 1, 0, 0,  0, 0, 32'h0,        0);
        tbl[13] = mk(1, 1, 12, 32'h0,        0, 32'h0,        0, 0, 0,  1, 1, 0,  1, 10, 32'h0000_1010, 0);
        tbl[14] = mk(0, 0, 0, 32'h0,         1, 32'h0000_0BAD, 1, 0, 0,  0, 0, 0,  0, 0, 32'h0,        0);
        tbl[15] = mk(0, 0, 0, 32'h0,         0, 32'h0,        0, 11, 0, 1, 1, 0,  0, 0, 32'h0,        1);
        tbl[16] = mk(0, 0, 0, 32'h0,         1, 32'h0000_C0DE, 0, 0, 0,  0, 0, 0,  0, 0, 32'h0,        0);
        tbl[17] = mk(0, 0, 0, 32'h0,         0, 32'h0,        0, 0, 0,  1, 1, 0,  1, 12, 32'h0000_C0DE, 0);
        tbl[18] = mk(0, 0, 0, 32'h0,         1, 32'h0000_5555, 0, 0, 0,  0, 0, 0,  0, 0, 32'h0,        0);
        tbl[19] = mk(0, 0, 0, 32'h0,         0, 32'h0,        0, 0, 0,  1, 1, 0,  0, 0, 32'h0,        1);
        tbl[20] = mk(0, 0, 0, 32'h0,         0, 32'h0,        0, 0, 0,  1, 1, 0,  0, 0, 32'h0,        0);

        rst_ni = 1'b0;
        idle();
        rf_rdata_a_i = 32'h1111_1111;
        rf_rdata_b_i = 32'h2222_2222;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("reset rf_we",    32'(rf_we_o),    32'h0);
        check("reset rf_waddr", 32'(rf_waddr_o), 32'h0);
        check("reset rf_wdata", rf_wdata_o,      32'h0);
        check("reset err",      32'(err_o),      32'h0);
        check("reset stall",    32'(stall_o),    32'h0);
        check("reset ex_ready", 32'(ex_ready_o), 32'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Table of directed cycles.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk_i);
            #1;
            drive(tbl[i].v, tbl[i].ld, tbl[i].rd, tbl[i].wd, tbl[i].rv, tbl[i].rdt, tbl[i].er,
                  tbl[i].ra, tbl[i].rb);
            rf_rdata_a_i = 32'h1000_0000 + 32'(i);
            rf_rdata_b_i = 32'h2000_0000 + 32'(i);
            @(negedge clk_i);
            if (tbl[i].ck_rdy)
                check($sformatf("row%0d ex_ready", i), 32'(ex_ready_o), 32'(tbl[i].e_rdy));
            check($sformatf("row%0d stall", i),  32'(stall_o), 32'(tbl[i].e_stall));
            check($sformatf("row%0d rf_we", i),  32'(rf_we_o), 32'(tbl[i].e_we));
            check($sformatf("row%0d err", i),    32'(err_o),   32'(tbl[i].e_err));
            check($sformatf("row%0d fwd_a", i),  fwd_a_o, 32'h1000_0000 + 32'(i));
            check($sformatf("row%0d fwd_b", i),  fwd_b_o, 32'h2000_0000 + 32'(i));
            if (tbl[i].e_we) begin
                check($sformatf("row%0d rf_waddr", i), 32'(rf_waddr_o), 32'(tbl[i].e_wa));
                check($sformatf("row%0d rf_wdata", i), rf_wdata_o, tbl[i].e_wd);
            end
        end

        // Decode reads the register being written from the slot.
        @(posedge clk_i);
        #1 drive(1'b1, 1'b0, 5'd9, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        rf_rdata_a_i = 32'h1111_1111;
        rf_rdata_b_i = 32'h2222_2222;
        @(negedge clk_i);
        check("byp ex_ready", 32'(ex_ready_o), 32'h1);
        @(posedge clk_i);
        #1 drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd9);
        @(negedge clk_i);
        check("byp rf_we",    32'(rf_we_o),    32'h1);
        check("byp rf_waddr", 32'(rf_waddr_o), 32'd9);
        check("byp fwd_a",    fwd_a_o,         32'h1111_1111);
`ifdef IBEX_RF_WB_BYPASS_EN
        check("byp fwd_b",    fwd_b_o,         32'hA5A5_A5A5);
        check("byp stall",    32'(stall_o),    32'h0);
`else
        check("byp fwd_b",    fwd_b_o,         32'h2222_2222);
        check("byp stall",    32'(stall_o),    32'h1);
`endif

        // Reset while a load is outstanding.
        @(posedge clk_i);
        #1 drive(1'b1, 1'b1, 5'd7, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
        @(posedge clk_i);
        #1 drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd7, 5'd0);
        @(negedge clk_i);
        check("pre-rst stall", 32'(stall_o), 32'h1);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("mid-rst stall",    32'(stall_o),    32'h0);
        check("mid-rst ex_ready", 32'(ex_ready_o), 32'h0);
        check("mid-rst rf_we",    32'(rf_we_o),    32'h0);
        check("mid-rst rf_waddr", 32'(rf_waddr_o), 32'h0);
        check("mid-rst rf_wdata", rf_wdata_o,      32'h0);
        check("mid-rst err",      32'(err_o),      32'h0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("post-rst stall",    32'(stall_o),    32'h0);
        check("post-rst ex_ready", 32'(ex_ready_o), 32'h1);
        @(posedge clk_i);
        #1 drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_7777, 1'b0, 5'd0, 5'd0);
        @(posedge clk_i);
        #1 idle();
        @(negedge clk_i);
        check("stale resp err",   32'(err_o),   32'h1);
        check("stale resp rf_we", 32'(rf_we_o), 32'h0);
        @(negedge clk_i);
        check("stale resp err end", 32'(err_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibex_rf_wb_stage.md
Name: ibex_rf_wb_stage

Overview:
Writeback stage directly upstream of the FPGA register file write port. It merges execute-stage results and in-order LSU load responses into one registered writeback slot, then drives the register file's single write port. It tracks outstanding load destinations and raises operand-hazard stalls toward decode. Because the register file write is synchronous, the stage also supplies a same-cycle bypass for the decode read ports.

Parameters:
RV32E, 0, 1 restricts register addresses to 16 registers (upper address bit must be 0).
DataWidth, 32, width of register data.
NumRegs, 32, number of architectural registers; ADDR_WIDTH = $clog2(NumRegs).
MaxLoads, 2, maximum outstanding loads (depth of the pending-rd FIFO, >=1).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ex_valid_i  in  1  execute result or load issue valid
ex_ready_o  out  1  stage accepts the ex beat this cycle
ex_is_load_i  in  1  beat is a load issue (rd recorded, no data)
ex_rd_i  in  ADDR_WIDTH  destination register
ex_wdata_i  in  DataWidth  result data (ignored for loads)
lsu_resp_valid_i  in  1  load response valid (in order)
lsu_rdata_i  in  DataWidth  load data
lsu_err_i  in  1  load response is a bus error
rs_a_i / rs_b_i  in  ADDR_WIDTH each  decode source registers
stall_o  out  1  decode must hold (operand hazard)
fwd_a_o / fwd_b_o  out  DataWidth each  operand a/b value (bypass or pass-through)
rf_rdata_a_i / rf_rdata_b_i  in  DataWidth each  register file read data
rf_waddr_o  out  ADDR_WIDTH  register file write address
rf_wdata_o  out  DataWidth  register file write data
rf_we_o  out  1  register file write enable
err_o  out  1  one-cycle pulse on load error or unexpected response

Behaviour:
- Reset (async, rst_ni low): wb_valid_q=0, wb_rd_q=0, wb_data_q=0, FIFO empty (count 0, pointers 0). Outputs: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, err_o=0, stall_o=0, ex_ready_o=0 while in reset. Reset mid-operation discards all pending loads; later responses are treated as unexpected.
- Writeback slot is loaded every cycle (single-beat pipeline register):
  - LSU response valid, no error, FIFO non-empty: slot <= {1, FIFO head rd, lsu_rdata_i}; pop.
  - Else, ex beat accepted and not a load: slot <= {1, ex_rd_i, ex_wdata_i}.
  - Else: wb_valid_q <= 0.
- rf_we_o = wb_valid_q && wb_rd_q != 0; rf_waddr_o = wb_rd_q; rf_wdata_o = wb_data_q. Data reaches the register file exactly 1 cycle after acceptance.
- ex_ready_o is low when any of the following holds:
  - lsu_resp_valid_i with a non-load ex beat (response wins the slot);
  - load issue with FIFO full;
  - ex_rd_i != 0 matches any pending FIFO rd (WAW ordering).
  Otherwise ex_ready_o is high.
- Accepted load issue pushes ex_rd_i; rd 0 is still pushed to keep response ordering. Simultaneous push and pop with FIFO full is allowed; count is unchanged. Pointers wrap modulo MaxLoads.
- lsu_err_i with a valid response: pop, no write, err_o=1 next cycle.
- Response with empty FIFO: ignored, err_o=1 next cycle.
- stall_o = (rs_a_i != 0 and matches a pending FIFO rd) or (rs_b_i likewise). Register 0 never stalls.
- RV32E=1: ex_rd_i with MSB set is still written; RV32E range checking is decode's job.

Optional Feature:
IBEX_RF_WB_BYPASS_EN
- Defined: fwd_x_o = wb_data_q when wb_valid_q && wb_rd_q != 0 && rs_x_i == wb_rd_q; else rf_rdata_x_i.
- Undefined: fwd_x_o = rf_rdata_x_i always. stall_o additionally asserts when wb_valid_q && wb_rd_q != 0 && rs_x_i == wb_rd_q (1-cycle bubble).

Decomposition:
- Shared package ibex_pkg: wb_slot_t struct {valid, rd, data} parameterised via localparam widths; constant for the zero register address.
- One sub-module: ibex_rf_wb_ld_fifo, the MaxLoads-deep rd FIFO. Outputs: head rd, full, empty, and a per-entry valid/rd vector for match logic.

Test Plan:
- ALU ex beat rd=5, data 0x1234_5678 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234_5678; rd=0 beat -> rf_we_o=0.
- Issue load rd=7, then response 0xDEAD_BEEF -> rd 7 written one cycle later. rs_a_i=7 holds stall_o=1 from issue until the pop cycle.
- Response and ALU beat (rd=3) in the same cycle -> ex_ready_o=0; load writes first, ALU beat accepted next cycle and written after.
- Two loads issued (MaxLoads=2), third load issue -> ex_ready_o=0 until a response pops. ALU beat to rd 7 while a load to rd 7 is pending -> ex_ready_o=0.
- lsu_err_i response -> no rf_we_o, err_o pulse of 1 cycle. Response with FIFO empty -> err_o pulse. Assert rst_ni low with a load pending -> FIFO cleared, outputs 0.
- With the bypass macro: rs_b_i equal to the slot rd=9 (data 0xA5A5_A5A5) -> fwd_b_o=0xA5A5_A5A5, stall_o=0. Without the macro -> stall_o=1 for that cycle.
